// File: rtl/bsg_fifo_1r1w_rolly_multi.sv
// bsg_fifo_1r1w_rolly_multi
//
// Speculative FIFO with three pointers:
//   cptr - commit point; entries older than this are gone for good
//   rptr - next entry presented to the consumer
//   wptr - next slot to be written
// Entries read by the consumer stay resident until committed. A roll rewinds
// rptr to the (post-commit) commit point and replays everything uncommitted.
// A clear drops every unread entry by pulling wptr back to the new rptr.
// Up to max_cmt_p entries can be committed per cycle.
//
// Ports:
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset (pointers only, storage kept)
//   data_i/v_i     enqueue payload / valid, accepted when ready_o=1
//   ready_o        not full and no clear this cycle
//   data_o/v_o     head-of-read payload (combinational read) / valid
//   yumi_i         consumer takes data_o; only legal while v_o=1
//   cmt_v_i        commit request, cmt_cnt_i entries (1..max_cmt_p)
//   roll_v_i       rewind rptr to the commit point
//   clr_v_i        drop all unread entries
//   spec_count_o   wptr - rptr (unread entries)
//   total_count_o  wptr - cptr (resident entries)

module bsg_fifo_1r1w_rolly_multi #(
  parameter int width_p   = 64,
  parameter int els_p     = 8,
  parameter int max_cmt_p = 2,
  localparam int ptr_width_lp = ((els_p <= 1) ? 1 : $clog2(els_p)) + 1,
  localparam int cnt_width_lp = ((els_p + 1 <= 1) ? 1 : $clog2(els_p + 1)),
  localparam int cmt_width_lp = ((max_cmt_p + 1 <= 1) ? 1 : $clog2(max_cmt_p + 1))
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [width_p-1:0]      data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  input  logic                    cmt_v_i,
  input  logic [cmt_width_lp-1:0] cmt_cnt_i,
  input  logic                    roll_v_i,
  input  logic                    clr_v_i,
  output logic [cnt_width_lp-1:0] spec_count_o,
  output logic [cnt_width_lp-1:0] total_count_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;

  logic [width_p-1:0] mem_q [els_p];

  logic empty, full, enq, read;
  logic [ptr_width_lp-1:0] cmt_inc;

  // Flags come from registered pointers only, so a commit that frees space
  // cannot open ready_o until the cycle after.
  assign empty = (rptr_q == wptr_q);
  assign full  = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
              && (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1]);

  assign ready_o = ~full & ~clr_v_i;
  assign v_o     = ~empty & ~roll_v_i;
  assign enq     = v_i & ready_o;
  assign read    = yumi_i;

  assign data_o = mem_q[rptr_q[idx_width_lp-1:0]];

  assign spec_count_o  = cnt_width_lp'(wptr_q - rptr_q);
  assign total_count_o = cnt_width_lp'(wptr_q - cptr_q);

  // Next-state chain: commit first, then roll lands on the post-commit
  // point, then clear collapses wptr onto the resulting rptr.
  always_comb begin
    cmt_inc = '0;
    if (cmt_v_i) begin
      cmt_inc = ptr_width_lp'(cmt_cnt_i);
    end
    cptr_d = cptr_q + cmt_inc;
    rptr_d = roll_v_i ? cptr_d : (rptr_q + ptr_width_lp'(read));
    wptr_d = clr_v_i  ? rptr_d : (wptr_q + ptr_width_lp'(enq));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cptr_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      cptr_q <= cptr_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  // Storage has no reset; stale contents are hidden behind v_o.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
    end
  end

`ifndef SYNTHESIS
  localparam int room_width_lp = ptr_width_lp + 1;

  logic [ptr_width_lp-1:0]  read_minus_cmt;
  logic [room_width_lp-1:0] cmt_room;

  // A commit may cover everything already read plus the entry read this cycle.
  assign read_minus_cmt = rptr_q - cptr_q;
  assign cmt_room = room_width_lp'(read_minus_cmt) + room_width_lp'(read);

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!cmt_v_i || ((cmt_cnt_i != '0)
              && (room_width_lp'(cmt_cnt_i) <= cmt_room)))
        else $error("illegal commit count %0d (room %0d)", cmt_cnt_i, cmt_room);
      assert (!yumi_i || v_o)
        else $error("yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_multi.sv
// Directed and random checks of bsg_fifo_1r1w_rolly_multi (els_p=4,
// max_cmt_p=2, 8-bit payload). A queue model holds the resident entries from
// the commit point onward plus a read offset; it is updated at each clock edge
// from the driven stimulus and compared against the DUT outputs.

module tb_bsg_fifo_1r1w_rolly_multi;

  localparam int W = 8;
  localparam int E = 4;
  localparam int M = 2;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [W-1:0] data_i;
  logic         v_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         v_o;
  logic         yumi_i;
  logic         cmt_v_i;
  logic [1:0]   cmt_cnt_i;
  logic         roll_v_i;
  logic         clr_v_i;
  logic [2:0]   spec_count_o;
  logic [2:0]   total_count_o;

  int checks = 0;
  int passed = 0;

  // Model: res_q[0] is the entry at cptr; rd_off = rptr - cptr.
  logic [W-1:0] res_q[$];
  int           rd_off = 0;

  bsg_fifo_1r1w_rolly_multi #(
    .width_p  (W),
    .els_p    (E),
    .max_cmt_p(M)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .data_i       (data_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .cmt_v_i      (cmt_v_i),
    .cmt_cnt_i    (cmt_cnt_i),
    .roll_v_i     (roll_v_i),
    .clr_v_i      (clr_v_i),
    .spec_count_o (spec_count_o),
    .total_count_o(total_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    v_i       = 1'b0;
    data_i    = '0;
    yumi_i    = 1'b0;
    cmt_v_i   = 1'b0;
    cmt_cnt_i = '0;
    roll_v_i  = 1'b0;
    clr_v_i   = 1'b0;
  endtask

  // Inputs idle: compare every output against the model.
  task automatic check_idle(input string tag);
    int sz;
    #1;
    sz = res_q.size();
    chk({tag, ".spec"},  32'(spec_count_o),  32'(sz - rd_off));
    chk({tag, ".total"}, 32'(total_count_o), 32'(sz));
    chk({tag, ".v_o"},   32'(v_o),           32'(sz > rd_off));
    chk({tag, ".ready"}, 32'(ready_o),       32'(sz < E));
    if (sz > rd_off) chk({tag, ".data"}, 32'(data_o), 32'(res_q[rd_off]));
  endtask

  // Called shortly after a negedge: drive one cycle of stimulus, check the
  // combinational handshake outputs, clock it, update the model, check state.
  task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                      input logic c, input int cnt, input logic r,
                      input logic cl, input string tag);
    logic exp_ready, exp_v, enq;
    v_i       = v;
    data_i    = d;
    yumi_i    = y;
    cmt_v_i   = c;
    cmt_cnt_i = 2'(cnt);
    roll_v_i  = r;
    clr_v_i   = cl;
    #1;
    exp_ready = (res_q.size() < E) && !cl;
    exp_v     = (res_q.size() > rd_off) && !r;
    chk({tag, ".pre_ready"}, 32'(ready_o), 32'(exp_ready));
    chk({tag, ".pre_v_o"},   32'(v_o),     32'(exp_v));
    if (exp_v) chk({tag, ".pre_data"}, 32'(data_o), 32'(res_q[rd_off]));
    enq = v && exp_ready;
    @(posedge clk_i);
    if (c) begin
      repeat (cnt) void'(res_q.pop_front());
    end
    rd_off = rd_off + (y ? 1 : 0) - (c ? cnt : 0);
    if (r) rd_off = 0;
    if (cl) begin
      while (res_q.size() > rd_off) void'(res_q.pop_back());
    end else if (enq) begin
      res_q.push_back(d);
    end
    @(negedge clk_i);
    idle_inputs();
    check_idle(tag);
  endtask

  // Pulse the async reset between edges and clear the model.
  task automatic do_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    #1;
    reset_n_i = 1'b1;
    res_q.delete();
    rd_off = 0;
    check_idle("reset_pulse");
  endtask

  initial begin
    logic r, y, c, cl, v;
    int   avail, cnt;
    logic [W-1:0] d;

    idle_inputs();
    reset_n_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rst_held.v_o",   32'(v_o),           32'(0));
    chk("rst_held.ready", 32'(ready_o),       32'(1));
    chk("rst_held.spec",  32'(spec_count_o),  32'(0));
    chk("rst_held.total", 32'(total_count_o), 32'(0));
    reset_n_i = 1'b1;
    check_idle("rst_release");

    // 1. Fill to full: data_o stays 0x10, ready_o drops after the 4th edge.
    step(1, 8'h10, 0, 0, 0, 0, 0, "fill0");
    step(1, 8'h11, 0, 0, 0, 0, 0, "fill1");
    step(1, 8'h12, 0, 0, 0, 0, 0, "fill2");
    step(1, 8'h13, 0, 0, 0, 0, 0, "fill3");
    chk("fill.ready_low", 32'(ready_o), 32'(0));
    chk("fill.data_head", 32'(data_o),  32'(8'h10));

    // 2. Read two, then commit one together with a roll.
    step(0, 8'h00, 1, 0, 0, 0, 0, "read10");
    step(0, 8'h00, 1, 0, 0, 0, 0, "read11");
    step(0, 8'h00, 0, 1, 1, 1, 0, "cmt1_roll");
    chk("roll.data",  32'(data_o),        32'(8'h11));
    chk("roll.spec",  32'(spec_count_o),  32'(3));
    chk("roll.total", 32'(total_count_o), 32'(3));

    // 3. Clear with a simultaneous enqueue attempt, then roll back to 0xA0.
    do_reset();
    step(1, 8'hA0, 0, 0, 0, 0, 0, "enqA0");
    step(1, 8'hA1, 0, 0, 0, 0, 0, "enqA1");
    step(1, 8'hA2, 0, 0, 0, 0, 0, "enqA2");
    step(0, 8'h00, 1, 0, 0, 0, 0, "readA0");
    step(1, 8'hA3, 0, 0, 0, 0, 1, "clr_enq");
    chk("clr.total", 32'(total_count_o), 32'(1));
    step(0, 8'h00, 0, 0, 0, 1, 0, "roll_after_clr");
    chk("clr_roll.data", 32'(data_o), 32'(8'hA0));

    // 4. Multi-commit at full: enqueue blocked in the commit cycle.
    do_reset();
    step(1, 8'h20, 0, 0, 0, 0, 0, "mc_fill0");
    step(1, 8'h21, 0, 0, 0, 0, 0, "mc_fill1");
    step(1, 8'h22, 0, 0, 0, 0, 0, "mc_fill2");
    step(1, 8'h23, 0, 0, 0, 0, 0, "mc_fill3");
    step(0, 8'h00, 1, 0, 0, 0, 0, "mc_read0");
    step(0, 8'h00, 1, 0, 0, 0, 0, "mc_read1");
    step(1, 8'h24, 0, 1, 2, 0, 0, "mc_cmt2_enq");
    chk("mc.total_after_cmt", 32'(total_count_o), 32'(2));
    step(1, 8'h25, 0, 0, 0, 0, 0, "mc_enq_after");
    chk("mc.total_after_enq", 32'(total_count_o), 32'(3));

    // 5. Random legal traffic; pointers wrap several times.
    for (int i = 0; i < 40; i++) begin
      r     = ($urandom_range(0, 7) == 0);
      y     = !r && (res_q.size() > rd_off) && ($urandom_range(0, 1) == 1);
      avail = rd_off + (y ? 1 : 0);
      c     = (avail > 0) && ($urandom_range(0, 2) != 0);
      cnt   = 0;
      if (c) begin
        cnt = int'($urandom_range(1, M));
        if (cnt > avail) cnt = avail;
      end
      cl = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = W'($urandom_range(0, 255));
      step(v, d, y, c, cnt, r, cl, $sformatf("rnd%0d", i));
    end

    // 6. Async reset with three entries resident, asserted between edges.
    do_reset();
    step(1, 8'h01, 0, 0, 0, 0, 0, "ar_enq0");
    step(1, 8'h02, 0, 0, 0, 0, 0, "ar_enq1");
    step(1, 8'h03, 0, 0, 0, 0, 0, "ar_enq2");
    step(0, 8'h00, 1, 0, 0, 0, 0, "ar_read");
    reset_n_i = 1'b0;
    #1;
    chk("ar_held.v_o",   32'(v_o),           32'(0));
    chk("ar_held.ready", 32'(ready_o),       32'(1));
    chk("ar_held.spec",  32'(spec_count_o),  32'(0));
    chk("ar_held.total", 32'(total_count_o), 32'(0));
    reset_n_i = 1'b1;
    res_q.delete();
    rd_off = 0;
    step(1, 8'h55, 0, 0, 0, 0, 0, "ar_enq55");
    chk("ar.data55", 32'(data_o), 32'(8'h55));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
